// File: rtl/dmem_arbiter.sv
// Two-port req/gnt/done arbiter sequencing a single-port data memory with 2-cycle read latency.
// Optional round-robin arbitration when DMEM_ARB_RR_EN is defined; fixed priority (port 0) otherwise.
module dmem_arbiter #(
    parameter int unsigned DEPTH = 256,
    parameter int unsigned AW    = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          p0_req,
    input  logic          p0_we,
    input  logic [AW-1:0] p0_addr,
    input  logic [31:0]   p0_wdata,
    output logic          p0_gnt,
    output logic          p0_done,
    output logic [31:0]   p0_rdata,
    output logic          p0_err,
    input  logic          p1_req,
    input  logic          p1_we,
    input  logic [AW-1:0] p1_addr,
    input  logic [31:0]   p1_wdata,
    output logic          p1_gnt,
    output logic          p1_done,
    output logic [31:0]   p1_rdata,
    output logic          p1_err,
    output logic          mem_enable,
    output logic          mem_read,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_wdata,
    input  logic [31:0]   mem_rdata,
    output logic          busy
);

    localparam logic [2:0] StIdle    = 3'd0;
    localparam logic [2:0] StWr      = 3'd1;
    localparam logic [2:0] StRdIssue = 3'd2;
    localparam logic [2:0] StRdWait  = 3'd3;
    localparam logic [2:0] StRdData  = 3'd4;

    localparam logic [AW-1:0] DepthLim = AW'(DEPTH);

    logic [2:0]    state_q, state_d;
    logic          we_q, we_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic          port_q, port_d;
    logic          p0_done_q, p0_done_d, p1_done_q, p1_done_d;
    logic          p0_err_q, p0_err_d, p1_err_q, p1_err_d;
    logic [31:0]   p0_rdata_q, p0_rdata_d, p1_rdata_q, p1_rdata_d;

    logic          p0_win, p1_win, idle, any_gnt, oor;
    logic          sel_we;
    logic [AW-1:0] sel_addr;
    logic [31:0]   sel_wdata;

`ifdef DMEM_ARB_RR_EN
    // last_q = 1 means port 1 won last, so port 0 takes the next tie.
    logic last_q, last_d;
    assign p0_win = p0_req && (!p1_req || last_q);
    assign p1_win = p1_req && (!p0_req || !last_q);
`else
    assign p0_win = p0_req;
    assign p1_win = p1_req && !p0_req;
`endif

    assign idle      = (state_q == StIdle);
    assign p0_gnt    = idle && p0_win;
    assign p1_gnt    = idle && p1_win;
    assign any_gnt   = p0_gnt || p1_gnt;
    assign sel_we    = p1_gnt ? p1_we    : p0_we;
    assign sel_addr  = p1_gnt ? p1_addr  : p0_addr;
    assign sel_wdata = p1_gnt ? p1_wdata : p0_wdata;
    assign oor       = (sel_addr >= DepthLim);

    always_comb begin
        state_d    = state_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        port_d     = port_q;
        p0_done_d  = 1'b0;
        p1_done_d  = 1'b0;
        p0_err_d   = 1'b0;
        p1_err_d   = 1'b0;
        p0_rdata_d = p0_rdata_q;
        p1_rdata_d = p1_rdata_q;
`ifdef DMEM_ARB_RR_EN
        last_d     = last_q;
`endif
        case (state_q)
            StIdle: begin
                if (any_gnt) begin
`ifdef DMEM_ARB_RR_EN
                    last_d = p1_gnt;
`endif
                    if (oor) begin
                        // Rejected without touching memory; completes next cycle.
                        if (p1_gnt) begin
                            p1_done_d  = 1'b1;
                            p1_err_d   = 1'b1;
                            p1_rdata_d = 32'h0;
                        end else begin
                            p0_done_d  = 1'b1;
                            p0_err_d   = 1'b1;
                            p0_rdata_d = 32'h0;
                        end
                    end else begin
                        we_d    = sel_we;
                        addr_d  = sel_addr;
                        wdata_d = sel_wdata;
                        port_d  = p1_gnt;
                        state_d = sel_we ? StWr : StRdIssue;
                    end
                end
            end
            StWr: begin
                if (port_q) p1_done_d = 1'b1;
                else        p0_done_d = 1'b1;
                state_d = StIdle;
            end
            StRdIssue: state_d = StRdWait;
            StRdWait:  state_d = StRdData;
            StRdData: begin
                if (port_q) begin
                    p1_done_d  = 1'b1;
                    p1_rdata_d = mem_rdata;
                end else begin
                    p0_done_d  = 1'b1;
                    p0_rdata_d = mem_rdata;
                end
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= 32'h0;
            port_q     <= 1'b0;
            p0_done_q  <= 1'b0;
            p1_done_q  <= 1'b0;
            p0_err_q   <= 1'b0;
            p1_err_q   <= 1'b0;
            p0_rdata_q <= 32'h0;
            p1_rdata_q <= 32'h0;
`ifdef DMEM_ARB_RR_EN
            last_q     <= 1'b1;
`endif
        end else begin
            state_q    <= state_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            port_q     <= port_d;
            p0_done_q  <= p0_done_d;
            p1_done_q  <= p1_done_d;
            p0_err_q   <= p0_err_d;
            p1_err_q   <= p1_err_d;
            p0_rdata_q <= p0_rdata_d;
            p1_rdata_q <= p1_rdata_d;
`ifdef DMEM_ARB_RR_EN
            last_q     <= last_d;
`endif
        end
    end

    assign p0_done    = p0_done_q;
    assign p1_done    = p1_done_q;
    assign p0_err     = p0_err_q;
    assign p1_err     = p1_err_q;
    assign p0_rdata   = p0_rdata_q;
    assign p1_rdata   = p1_rdata_q;
    // Only WR may pull read low; every other state keeps the memory from writing.
    assign mem_read   = (state_q != StWr);
    assign mem_enable = (state_q == StRdIssue) || (state_q == StRdWait);
    assign mem_addr   = addr_q;
    assign mem_wdata  = wdata_q;
    assign busy       = !idle;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter with a behavioural 2-cycle-latency memory.
module tb_dmem_arbiter;
    localparam int unsigned DEPTH = 256;
    localparam int unsigned AW    = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          p0_req = 1'b0, p0_we = 1'b0, p1_req = 1'b0, p1_we = 1'b0;
    logic [AW-1:0] p0_addr = '0, p1_addr = '0;
    logic [31:0]   p0_wdata = '0, p1_wdata = '0;
    logic          p0_gnt, p0_done, p0_err, p1_gnt, p1_done, p1_err;
    logic [31:0]   p0_rdata, p1_rdata;
    logic          mem_enable, mem_read, busy;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic [31:0]   mem_rdata = '0;

    dmem_arbiter #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk(clk), .rst_n(rst_n),
        .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_gnt(p0_gnt), .p0_done(p0_done), .p0_rdata(p0_rdata), .p0_err(p0_err),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_gnt(p1_gnt), .p1_done(p1_done), .p1_rdata(p1_rdata), .p1_err(p1_err),
        .mem_enable(mem_enable), .mem_read(mem_read), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          port;
        bit          chk_rd;
        logic [31:0] rdata;
        bit          err;
        int          cyc;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    logic [31:0] model [DEPTH];
    logic [31:0] mem [DEPTH];
    logic [31:0] stage;
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          wr_low = 0;
    bit          obs_port, obs_err;
    logic [31:0] obs_rd;

    initial begin
        for (int i = 0; i < int'(DEPTH); i++) mem[i] = 32'(i * i);
    end

    // Memory: writes whenever read is low, read data two edges after enable.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!mem_read && mem_addr < AW'(DEPTH)) mem[mem_addr[7:0]] <= mem_wdata;
        if (mem_enable) begin
            stage     <= mem[mem_addr[7:0]];
            mem_rdata <= stage;
        end
    end

    always @(negedge clk) if (rst_n && !mem_read) wr_low <= wr_low + 1;

    always @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sb.delete();
        end else if (p0_done || p1_done) begin
            checks++;
            if (p0_done && p1_done) begin
                errors++;
                $display("FAIL both_done p0_done=1 p1_done=1 required one");
            end
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_done cyc=%0d p0_done=%0b p1_done=%0b required none",
                         cyc, p0_done, p1_done);
            end else begin
                mon_e    = sb.pop_front();
                obs_port = p1_done;
                obs_err  = p1_done ? p1_err : p0_err;
                obs_rd   = p1_done ? p1_rdata : p0_rdata;
                checks++;
                if (obs_port !== mon_e.port) begin
                    errors++;
                    $display("FAIL done_port got=%0d required=%0d", obs_port, mon_e.port);
                end
                checks++;
                if (cyc !== mon_e.cyc) begin
                    errors++;
                    $display("FAIL done_cycle got=%0d required=%0d", cyc, mon_e.cyc);
                end
                checks++;
                if (obs_err !== mon_e.err) begin
                    errors++;
                    $display("FAIL done_err got=%0b required=%0b", obs_err, mon_e.err);
                end
                if (mon_e.chk_rd) begin
                    checks++;
                    if (obs_rd !== mon_e.rdata) begin
                        errors++;
                        $display("FAIL done_rdata got=%h required=%h", obs_rd, mon_e.rdata);
                    end
                end
            end
        end
    end

    task automatic push_exp(input bit port, input bit we, input logic [31:0] addr,
                            input logic [31:0] wdata, input int gcyc);
        exp_t e;
        e.port   = port;
        e.err    = (addr >= 32'(DEPTH));
        e.chk_rd = !we || e.err;
        e.rdata  = e.err ? 32'h0 : model[addr[7:0]];
        if (we && !e.err) model[addr[7:0]] = wdata;
        e.cyc    = gcyc + (e.err ? 1 : (we ? 2 : 4));
        sb.push_back(e);
    endtask

    task automatic do_req(input bit port, input bit we, input logic [31:0] addr,
                          input logic [31:0] wdata, output int gcyc);
        bit got = 0;
        gcyc = -1;
        @(posedge clk); #1;
        if (port) begin
            p1_req = 1'b1; p1_we = we; p1_addr = addr; p1_wdata = wdata;
        end else begin
            p0_req = 1'b1; p0_we = we; p0_addr = addr; p0_wdata = wdata;
        end
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (port ? p1_gnt : p0_gnt) begin
                got  = 1;
                gcyc = cyc;
                push_exp(port, we, addr, wdata, gcyc);
            end else begin
                @(posedge clk); #1;
            end
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL gnt_timeout port=%0d got=none required=gnt", port);
        end
        @(posedge clk); #1;
        p0_req = 1'b0;
        p1_req = 1'b0;
    endtask

    task automatic wait_drain();
        bit ok = 0;
        for (int i = 0; i < 30 && !ok; i++) begin
            @(negedge clk);
            if (sb.size() == 0 && !busy) ok = 1;
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL drain_timeout pending=%0d busy=%0b required=0", sb.size(), busy);
        end
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if ({p0_gnt, p1_gnt, p0_done, p1_done, p0_err, p1_err, mem_enable, mem_read, busy}
            !== 9'b000000010) begin
            errors++;
            $display("FAIL reset_ctrl got=%b required=000000010",
                     {p0_gnt, p1_gnt, p0_done, p1_done, p0_err, p1_err, mem_enable, mem_read,
                      busy});
        end
        checks++;
        if ({p0_rdata, p1_rdata, mem_wdata, mem_addr} !== 128'h0) begin
            errors++;
            $display("FAIL reset_data got=%h %h %h %h required=0",
                     p0_rdata, p1_rdata, mem_wdata, mem_addr);
        end
        repeat (2) @(negedge clk);
        checks++;
        if (mem_read !== 1'b1 || mem_enable !== 1'b0) begin
            errors++;
            $display("FAIL reset_hold mem_read=%b mem_enable=%b required=1 0", mem_read,
                     mem_enable);
        end
        @(posedge clk); #1 rst_n = 1'b1;
    endtask

    task automatic test_write_read();
        int g;
        int w0 = wr_low;
        do_req(0, 1, 32'd5, 32'hDEADBEEF, g);
        wait_drain();
        do_req(0, 0, 32'd5, 32'h0, g);
        wait_drain();
        checks++;
        if (p0_rdata !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL wr_rd_data got=%h required=deadbeef", p0_rdata);
        end
        checks++;
        if (wr_low - w0 != 1) begin
            errors++;
            $display("FAIL wr_low_cycles got=%0d required=1", wr_low - w0);
        end
    endtask

    task automatic test_tie();
        bit order [3];
        int rem0 = 2, rem1 = 1, k = 0, last_g = -1;
`ifdef DMEM_ARB_RR_EN
        order = '{1'b0, 1'b1, 1'b0};
`else
        order = '{1'b0, 1'b0, 1'b1};
`endif
        @(posedge clk); #1;
        p0_req = 1'b1; p0_we = 1'b0; p0_addr = 32'd3;
        p1_req = 1'b1; p1_we = 1'b0; p1_addr = 32'd4;
        for (int i = 0; i < 40 && k < 3; i++) begin
            @(negedge clk);
            if (p0_gnt || p1_gnt) begin
                checks++;
                if ({p0_gnt, p1_gnt} !== {!order[k], order[k]}) begin
                    errors++;
                    $display("FAIL tie_order k=%0d got=%b%b required=%b%b", k, p0_gnt, p1_gnt,
                             !order[k], order[k]);
                end
                if (k > 0) begin
                    checks++;
                    if (cyc != last_g + 4) begin
                        errors++;
                        $display("FAIL tie_gnt_cycle got=%0d required=%0d", cyc, last_g + 4);
                    end
                end
                last_g = cyc;
                push_exp(p1_gnt, 1'b0, p1_gnt ? 32'd4 : 32'd3, 32'h0, cyc);
                if (p1_gnt) rem1--;
                else        rem0--;
                k++;
            end
            @(posedge clk); #1;
            p0_req = (rem0 > 0);
            p1_req = (rem1 > 0);
        end
        checks++;
        if (k != 3) begin
            errors++;
            $display("FAIL tie_timeout got=%0d required=3", k);
        end
        p0_req = 1'b0;
        p1_req = 1'b0;
        wait_drain();
    endtask

    task automatic test_oor();
        int g;
        do_req(1, 0, 32'd300, 32'h0, g);
        @(negedge clk);
        checks++;
        if ({mem_enable, mem_read, busy} !== 3'b010) begin
            errors++;
            $display("FAIL oor_mem got=%b required=010", {mem_enable, mem_read, busy});
        end
        wait_drain();
    endtask

    task automatic test_back_to_back();
        int cnt = 0, first = -1, last_g = -1;
        bit exp_busy;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            p0_req = (cnt < 4); p0_we = 1'b0; p0_addr = 32'(20 + cnt);
            @(negedge clk);
            exp_busy = (cnt > 0) && (cyc - last_g >= 1) && (cyc - last_g <= 3);
            checks++;
            if (busy !== exp_busy) begin
                errors++;
                $display("FAIL b2b_busy cyc=%0d got=%b required=%b", cyc, busy, exp_busy);
            end
            if (p0_gnt) begin
                if (cnt == 0) first = cyc;
                checks++;
                if (cyc != first + 4 * cnt || (cnt > 0 && !p0_done)) begin
                    errors++;
                    $display("FAIL b2b_gnt cyc=%0d done=%b required cyc=%0d done=1", cyc,
                             p0_done, first + 4 * cnt);
                end
                push_exp(1'b0, 1'b0, 32'(20 + cnt), 32'h0, cyc);
                last_g = cyc;
                cnt++;
            end
        end
        p0_req = 1'b0;
        checks++;
        if (cnt != 4) begin
            errors++;
            $display("FAIL b2b_count got=%0d required=4", cnt);
        end
        wait_drain();
    endtask

    task automatic test_reset_mid();
        int g;
        do_req(0, 0, 32'd7, 32'h0, g);
        @(posedge clk); #1;
        checks++;
        if ({busy, mem_enable} !== 2'b11) begin
            errors++;
            $display("FAIL mid_pre got=%b required=11", {busy, mem_enable});
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, mem_enable, mem_read} !== 3'b001) begin
            errors++;
            $display("FAIL mid_reset got=%b required=001", {busy, mem_enable, mem_read});
        end
        @(posedge clk); #1 rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            checks++;
            if (p0_done || p1_done) begin
                errors++;
                $display("FAIL mid_no_done got=%b%b required=00", p0_done, p1_done);
            end
        end
        do_req(0, 0, 32'd7, 32'h0, g);
        wait_drain();
    endtask

    task automatic test_isolation();
        @(posedge clk); #1;
        p1_req = 1'b1; p1_we = 1'b1; p1_addr = 32'd10; p1_wdata = 32'hCAFEF00D;
        p0_req = 1'b0;
        @(negedge clk);
        checks++;
        if ({p0_gnt, p1_gnt} !== 2'b01) begin
            errors++;
            $display("FAIL iso_p1_gnt got=%b required=01", {p0_gnt, p1_gnt});
        end
        if (p1_gnt) push_exp(1'b1, 1'b1, 32'd10, 32'hCAFEF00D, cyc);
        @(posedge clk); #1;
        p1_req = 1'b0;
        p0_req = 1'b1; p0_we = 1'b0; p0_addr = 32'd10;
        @(negedge clk);
        checks++;
        if ({p0_gnt, busy, mem_read} !== 3'b010) begin
            errors++;
            $display("FAIL iso_busy got=%b required=010", {p0_gnt, busy, mem_read});
        end
        @(posedge clk); #1 p0_req = 1'b0;
        @(negedge clk);
        checks++;
        if ({p0_gnt, p0_done, p1_done} !== 3'b001) begin
            errors++;
            $display("FAIL iso_done got=%b required=001", {p0_gnt, p0_done, p1_done});
        end
        @(posedge clk); #1 p0_req = 1'b1;
        @(negedge clk);
        checks++;
        if (p0_gnt !== 1'b1) begin
            errors++;
            $display("FAIL iso_p0_gnt got=%b required=1", p0_gnt);
        end
        if (p0_gnt) push_exp(1'b0, 1'b0, 32'd10, 32'h0, cyc);
        @(posedge clk); #1 p0_req = 1'b0;
        wait_drain();
    endtask

    initial begin
        for (int i = 0; i < int'(DEPTH); i++) model[i] = 32'(i * i);
        test_reset();
        test_write_read();
        test_tie();
        test_oor();
        test_back_to_back();
        test_reset_mid();
        test_isolation();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL leftover_expected got=%0d required=0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end
endmodule
